// File: rtl/f1_reaction_timer.sv
// Player-side reaction timer for the F1 start-light game: measures lights-out to
// button press in ms ticks, flags jump starts and timeouts, and tracks a best time.
module f1_reaction_timer #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           lights,
  input  logic                 tick_ms,
  input  logic                 button,
  input  logic                 clear_best,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 result_valid,
  output logic                 jump_start,
  output logic                 timed_out,
  output logic [CNT_WIDTH-1:0] best_time,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

  state_t               state;
  logic                 btn_s1, btn_s2, btn_prev;
  logic [7:0]           lights_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 press;
  logic                 lights_out_evt;

  // Button is asynchronous: two-flop synchroniser, then edge detect on the clean copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
      lights_q <= 8'h00;
    end else begin
      btn_s1   <= button;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      lights_q <= lights;
    end
  end

  assign press          = btn_s2 & ~btn_prev;
  assign lights_out_evt = (lights_q == 8'hFF) && (lights == 8'h00);
  assign cnt_nxt        = cnt + CNT_WIDTH'(tick_ms);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      react_time   <= '0;
      result_valid <= 1'b0;
      jump_start   <= 1'b0;
      timed_out    <= 1'b0;
      busy         <= 1'b0;
      best_time    <= '1;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (lights != 8'h00) begin
            state      <= ARMED;
            busy       <= 1'b1;
            jump_start <= 1'b0;
            timed_out  <= 1'b0;
            cnt        <= '0;
          end
        end
        ARMED: begin
          // A press coinciding with lights-out is still a jump start.
          if (press) begin
            state        <= DONE;
            busy         <= 1'b0;
            jump_start   <= 1'b1;
            react_time   <= '0;
            result_valid <= 1'b1;
          end else if (lights_out_evt) begin
            state <= TIMING;
            cnt   <= '0;
          end else if (lights == 8'h00) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        TIMING: begin
          if (press) begin
            state        <= DONE;
            busy         <= 1'b0;
            react_time   <= cnt_nxt;
            result_valid <= 1'b1;
          end else if (tick_ms && (cnt_nxt >= TMO)) begin
            state        <= DONE;
            busy         <= 1'b0;
            timed_out    <= 1'b1;
            react_time   <= TMO;
            result_valid <= 1'b1;
          end else if (lights != 8'h00) begin
            state      <= ARMED;
            jump_start <= 1'b0;
            timed_out  <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A fresh best result wins over a simultaneous clear request.
      if ((state == DONE) && !jump_start && !timed_out && (react_time < best_time))
        best_time <= react_time;
      else if (clear_best)
        best_time <= '1;
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer: stimulus pushes expected results,
// an independent monitor pops and compares whenever result_valid is seen.
module tb_f1_reaction_timer;
  localparam int W   = 16;
  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   lights;
  logic         tick_ms;
  logic         button;
  logic         clear_best;
  logic [W-1:0] react_time;
  logic         result_valid;
  logic         jump_start;
  logic         timed_out;
  logic [W-1:0] best_time;
  logic         busy;

  f1_reaction_timer #(.CNT_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .lights(lights), .tick_ms(tick_ms), .button(button),
    .clear_best(clear_best), .react_time(react_time), .result_valid(result_valid),
    .jump_start(jump_start), .timed_out(timed_out), .best_time(best_time), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] react;
    logic         jump;
    logic         tout;
    logic [W-1:0] best;
  } exp_t;

  exp_t         sb[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] m_best = '1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_result(input int r, input logic j, input logic t);
    exp_t e;
    e.react = W'(r);
    e.jump  = j;
    e.tout  = t;
    if (!j && !t && (W'(r) < m_best)) m_best = W'(r);
    e.best  = m_best;
    sb.push_back(e);
  endtask

  // Light bar fills from the left: level i shows i+1 lamps.
  task automatic ramp(input int upto);
    logic [7:0] full;
    full = 8'hFF;
    for (int i = 0; i <= upto; i++) begin
      lights = full >> (7 - i);
      repeat ($urandom_range(1, 3)) cyc();
    end
  endtask

  task automatic lights_out();
    ramp(7);
    lights = 8'h00;
    cyc();
    chk("busy_timing", busy, 1);
  endtask

  task automatic give_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      cyc();
      tick_ms = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  // Raw rise is acted on three edges later; 'extra' puts a tick on that edge.
  task automatic do_press(input int extra);
    button = 1'b1;
    cyc();
    cyc();
    tick_ms = (extra != 0);
    cyc();
    tick_ms = 1'b0;
    repeat (3) cyc();
    button = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic react_attempt(input int n, input int extra);
    lights_out();
    give_ticks(n);
    push_result(n + extra, 1'b0, 1'b0);
    do_press(extra);
  endtask

  task automatic timeout_attempt();
    lights_out();
    push_result(TMO, 1'b0, 1'b1);
    give_ticks(TMO);
    repeat (3) cyc();
    chk("busy_after_timeout", busy, 0);
  endtask

  task automatic jump_attempt(input int lvl);
    ramp(lvl);
    push_result(0, 1'b1, 1'b0);
    button = 1'b1;
    repeat (5) cyc();
    lights = 8'h00;
    button = 1'b0;
    repeat (4) cyc();
    chk("busy_after_jump", busy, 0);
  endtask

  task automatic abort_armed();
    ramp(3);
    lights = 8'h00;
    repeat (3) cyc();
    chk("busy_abort_armed", busy, 0);
  endtask

  task automatic abort_timing(input int n, input int extra);
    lights_out();
    give_ticks($urandom_range(1, 5));
    lights = 8'h01;
    cyc();
    chk("busy_rearmed", busy, 1);
    react_attempt(n, extra);
  endtask

  task automatic do_clear();
    clear_best = 1'b1;
    cyc();
    clear_best = 1'b0;
    m_best = '1;
    chk("best_cleared", best_time, 16'hFFFF);
  endtask

  // Monitor: every result pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got react=%0d jump=%0b tout=%0b expected none",
                   react_time, jump_start, timed_out);
        end else begin
          e = sb.pop_front();
          chk("react_time", react_time, e.react);
          chk("jump_start", jump_start, e.jump);
          chk("timed_out", timed_out, e.tout);
          @(negedge clk);
          chk("valid_one_cycle", result_valid, 0);
          chk("best_time", best_time, e.best);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; lights = 8'h00; tick_ms = 1'b0; button = 1'b0; clear_best = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_react", react_time, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_flags", {jump_start, timed_out}, 0);
    chk("rst_best", best_time, 16'hFFFF);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) cyc();

    // Press while idle is ignored.
    button = 1'b1; repeat (5) cyc(); button = 1'b0; repeat (4) cyc();

    jump_attempt(5);
    timeout_attempt();
    react_attempt(5, 0);
    do_clear();
    react_attempt(12, 0);
    react_attempt(7, 0);
    react_attempt(9, 0);
    do_clear();
    react_attempt(TMO - 1, 1);
    abort_armed();
    abort_timing(4, 1);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 5))
        0, 1: react_attempt($urandom_range(0, TMO - 1), $urandom_range(0, 1));
        2:    jump_attempt($urandom_range(0, 6));
        3:    timeout_attempt();
        4:    abort_armed();
        default: abort_timing($urandom_range(0, TMO - 1), $urandom_range(0, 1));
      endcase
      if ($urandom_range(0, 4) == 0) do_clear();
    end

    // Async reset mid-count: outputs must drop before any clock edge.
    react_attempt(3, 0);
    lights_out();
    give_ticks(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_react", react_time, 0);
    chk("arst_flags", {jump_start, timed_out}, 0);
    chk("arst_best", best_time, 16'hFFFF);
    m_best = '1;
    cyc();
    cyc();
    rst = 1'b0;
    button = 1'b1;
    repeat (8) cyc();
    button = 1'b0;
    repeat (4) cyc();
    chk("arst_busy_after", busy, 0);

    repeat (10) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Player-side counterpart to the F1 start-light sequencer. Watches the 8-bit light bar and the player's button, then reports one of three results:
  - reaction time, in millisecond ticks, from lights-out to the press;
  - jump start;
  - timeout.
- Keeps a best-time register. Sits beside the light sequencer at top level and drives the 7-seg/LED result display.

Parameters:
- CNT_WIDTH, 16, width of the reaction counter and the best-time register.
- TIMEOUT, 9999, tick count at which an unanswered lights-out is abandoned.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- lights  input  8  light bar from the sequencer; 8'hFF = all on, 8'h00 = out.
- tick_ms  input  1  single-cycle enable pulse, once per ms (from clktick).
- button  input  1  raw, asynchronous player button, active-high.
- clear_best  input  1  synchronous pulse; resets the best-time register.
- react_time  output  CNT_WIDTH  last measured reaction, in ticks.
- result_valid  output  1  one-cycle pulse when a result is posted.
- jump_start  output  1  sticky flag: last attempt was a jump start.
- timed_out  output  1  sticky flag: last attempt hit TIMEOUT.
- best_time  output  CNT_WIDTH  smallest valid react_time since reset/clear.
- busy  output  1  high in ARMED or TIMING.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; react_time=0; result_valid=0; jump_start=0; timed_out=0; busy=0.
  - best_time=all ones. Sync flops=0; lights_q=0.
- Button path:
  - 2-flop synchroniser, then a rising-edge detector on the synced signal.
  - press = synced & ~synced_prev.
  - 3 cycles from a raw rise to press.
- lights_q register: holds the previous cycle's lights value.
  - lights_out_evt = (lights_q==8'hFF) && (lights==8'h00).
- FSM:
  - IDLE:
    - lights!=0 -> ARMED. On entry, clear jump_start and timed_out; clear the counter.
    - A press in IDLE is ignored.
  - ARMED:
    - press -> DONE with jump_start=1, react_time=0.
    - Otherwise lights_out_evt -> TIMING, counter=0.
    - Otherwise lights==0 with lights_q!=FF (sequence aborted) -> IDLE, no result.
    - If press and lights_out_evt fall in the same cycle, the press wins (jump start).
  - TIMING:
    - Counter increments on each tick_ms.
    - press -> DONE, react_time=counter value, with the same-cycle tick included.
    - Otherwise counter+tick reaching TIMEOUT -> DONE with timed_out=1, react_time=TIMEOUT.
    - Press and the timeout tick in the same cycle: the press wins, react_time=TIMEOUT.
    - lights!=0 while timing (sequencer restarted) -> ARMED, no result.
  - DONE:
    - Exactly one cycle. result_valid=1.
    - best_time updates on the next edge when neither flag is set and react_time<best_time.
    - Then -> IDLE.
- Counter: CNT_WIDTH wide, never wraps; bounded by TIMEOUT (TIMEOUT < 2^CNT_WIDTH).
- clear_best: sets best_time to all ones next cycle. A best_time update in the same cycle takes priority over clear_best.
- react_time and the flags hold their values until the next result or until entry to ARMED.
  - Exception: react_time holds across ARMED entry and changes only when a result is posted.
- Reset mid-operation: returns to IDLE at once, with no result_valid.

Test Plan:
- Normal reaction: lights ramp 01..FF, then 00; 5 tick_ms pulses; raw button rises -> result_valid one cycle, react_time=5, jump_start=0, timed_out=0, best_time=5.
- Jump start: button rises while lights=8'h3F -> result_valid, jump_start=1, react_time=0, best_time unchanged (all ones).
- Timeout with TIMEOUT=20: lights FF->00, no press, 20 ticks -> result_valid, timed_out=1, react_time=20, best_time unchanged.
- Best tracking: results 12, then 7, then 9 -> best_time reads 12, 7, 7. Then clear_best -> best_time=16'hFFFF.
- Abort paths:
  - lights drop 8'h0F->00 in ARMED -> back to IDLE, no result_valid.
  - lights go 00->01 during TIMING -> ARMED, no result_valid.
- Async reset asserted mid-TIMING at count 3 -> all outputs at reset values immediately, without waiting for a clk edge; busy=0; no result_valid after release.
